// File: rtl/mmcs_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mmcs_pkg : shared state encoding and slice helpers  (Rev 1.0)    |
// +------------------------------------------------------------------+
package mmcs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_WR = 3'd1,
    ST_WAIT_RD = 3'd2,
    ST_ERROR   = 3'd3
  } state_e;

  localparam int REQ_BIT = 1;
  localparam int RD_BIT  = 0;

  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

  // An index port never collapses to zero width, even with a single master.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_sync_edge.sv
`default_nettype none
// +------------------------------------------------------------------+
// | btn_sync_edge : 2-flop synchroniser + registered rise pulse (1.0)|
// +------------------------------------------------------------------+
module btn_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic pulse_o
);

  logic meta_q, sync_q, prev_q, pulse_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      meta_q  <= btn_i;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      pulse_q <= sync_q & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule
`default_nettype wire

// File: rtl/multi_master_cmd_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | multi_master_cmd_sequencer : button-launched bus command (1.0)   |
// +------------------------------------------------------------------+
module multi_master_cmd_sequencer
  import mmcs_pkg::*;
#(
  parameter int NUM_M       = 2,
  parameter int ADDR_LEN    = 12,
  parameter int DATA_LEN    = 8,
  parameter int BURST_LEN   = 12,
  parameter int SLAVE_LEN   = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          btn_go,
  input  logic                          btn_abort,
  input  logic [idx_width(NUM_M)-1:0]   cmd_master,
  input  logic [SLAVE_LEN-1:0]          cmd_slave,
  input  logic [ADDR_LEN-1:0]           cmd_addr,
  input  logic [DATA_LEN-1:0]           cmd_data,
  input  logic [BURST_LEN-1:0]          cmd_burst,
  input  logic                          cmd_read,
  output logic [NUM_M*ADDR_LEN-1:0]     m_addr,
  output logic [NUM_M*DATA_LEN-1:0]     m_data,
  output logic [NUM_M*BURST_LEN-1:0]    m_burst,
  output logic [NUM_M*SLAVE_LEN-1:0]    m_slave,
  output logic [NUM_M*2-1:0]            m_instr,
  input  logic [NUM_M-1:0]              m_tx_done,
  input  logic [NUM_M-1:0]              m_new_rx,
  input  logic [NUM_M-1:0]              m_rx_done,
  input  logic [NUM_M*DATA_LEN-1:0]     m_new_data,
  output logic [DATA_LEN-1:0]           rd_data,
  output logic                          rd_valid,
  output logic [BURST_LEN-1:0]          rd_count,
  output logic                          busy,
  output logic                          err_timeout,
  output logic [2:0]                    state_o
);

  localparam int MW = idx_width(NUM_M);
  localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  state_e                state_q, state_d;
  logic [MW-1:0]         sel_q, sel_d;
  logic [ADDR_LEN-1:0]   addr_q, addr_d;
  logic [DATA_LEN-1:0]   data_q, data_d;
  logic [BURST_LEN-1:0]  burst_q, burst_d;
  logic [SLAVE_LEN-1:0]  slave_q, slave_d;
  logic                  read_q, read_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_LEN-1:0]   rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [BURST_LEN-1:0]  rd_count_q, rd_count_d;
  logic                  err_q, err_d;

  logic go_p, abort_p, active, timeout_hit;
  logic tx_done_s, new_rx_s, rx_done_s;
  logic [DATA_LEN-1:0] new_data_s;

  btn_sync_edge u_go_sync    (.clk(clk), .reset(reset), .btn_i(btn_go),    .pulse_o(go_p));
  btn_sync_edge u_abort_sync (.clk(clk), .reset(reset), .btn_i(btn_abort), .pulse_o(abort_p));

  assign active      = (state_q == ST_WAIT_WR) || (state_q == ST_WAIT_RD);
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CW'(TIMEOUT_CYC - 1));

  // Only the selected master's completion/beat inputs are ever observed.
  always_comb begin
    tx_done_s  = 1'b0;
    new_rx_s   = 1'b0;
    rx_done_s  = 1'b0;
    new_data_s = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (sel_q == MW'(i)) begin
        tx_done_s  = m_tx_done[i];
        new_rx_s   = m_new_rx[i];
        rx_done_s  = m_rx_done[i];
        new_data_s = m_new_data[slice_lo(i, DATA_LEN) +: DATA_LEN];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    addr_d     = addr_q;
    data_d     = data_q;
    burst_d    = burst_q;
    slave_d    = slave_q;
    read_d     = read_q;
    cnt_d      = cnt_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_count_d = rd_count_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (go_p && (int'(cmd_master) < NUM_M)) begin
          sel_d      = cmd_master;
          addr_d     = cmd_addr;
          data_d     = cmd_read ? '0 : cmd_data;
          burst_d    = cmd_burst;
          slave_d    = cmd_slave;
          read_d     = cmd_read;
          cnt_d      = '0;
          rd_count_d = '0;
          err_d      = 1'b0;
          state_d    = cmd_read ? ST_WAIT_RD : ST_WAIT_WR;
        end
      end
      ST_WAIT_WR: begin
        if (abort_p || tx_done_s) begin
          state_d = ST_IDLE;
        end else if (timeout_hit) begin
          state_d = ST_ERROR;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WAIT_RD: begin
        if (abort_p) begin
          state_d = ST_IDLE;
        end else begin
          // A beat arriving with rx_done is still captured before finishing.
          if (new_rx_s) begin
            rd_data_d  = new_data_s;
            rd_valid_d = 1'b1;
            rd_count_d = rd_count_q + BURST_LEN'(1);
            cnt_d      = '0;
          end
          if (rx_done_s) begin
            state_d = ST_IDLE;
          end else if (!new_rx_s) begin
            if (timeout_hit) begin
              state_d = ST_ERROR;
              err_d   = 1'b1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      burst_q    <= '0;
      slave_q    <= '0;
      read_q     <= 1'b0;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_count_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      burst_q    <= burst_d;
      slave_q    <= slave_d;
      read_q     <= read_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_count_q <= rd_count_d;
      err_q      <= err_d;
    end
  end

  for (genvar i = 0; i < NUM_M; i++) begin : g_master
    logic hit;
    assign hit = active && (sel_q == MW'(i));
    assign m_addr[slice_lo(i, ADDR_LEN) +: ADDR_LEN]    = hit ? addr_q  : '0;
    assign m_data[slice_lo(i, DATA_LEN) +: DATA_LEN]    = hit ? data_q  : '0;
    assign m_burst[slice_lo(i, BURST_LEN) +: BURST_LEN] = hit ? burst_q : '0;
    assign m_slave[slice_lo(i, SLAVE_LEN) +: SLAVE_LEN] = hit ? slave_q : '0;
    assign m_instr[slice_lo(i, 2) + REQ_BIT]            = hit;
    assign m_instr[slice_lo(i, 2) + RD_BIT]             = hit & read_q;
  end

  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign rd_count    = rd_count_q;
  assign busy        = active;
  assign err_timeout = err_q;
  assign state_o     = state_q;

endmodule
`default_nettype wire
